// File: rtl/rx_frame_buffer_pkg.sv
// rx_frame_buffer_pkg: word-field offsets, bad-FCS marker, ingress states and small helpers
package rx_frame_buffer_pkg;
  localparam int WORD_W   = 37;
  localparam int LAST_BIT = 36;
  localparam int DATA_LSB = 4;
  localparam int KEEP_MSB = 3;
  localparam logic [WORD_W-1:0] BAD_MARKER = (WORD_W'(1) << LAST_BIT) | (WORD_W'(1) << DATA_LSB);
  typedef enum logic [1:0] {IDLE, RECV, DROP} ing_state_e;
  function automatic logic [15:0] keep_bytes(input logic [KEEP_MSB:0] k);
    return 16'(k[0]) + 16'(k[1]) + 16'(k[2]) + 16'(k[3]);
  endfunction
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return &c ? c : c + 16'd1;
  endfunction
endpackage

// File: rtl/rx_frame_buffer_desc_fifo.sv
// desc_fifo: frame-length descriptor queue with req/ack handshake on both sides
module desc_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data_i,
  input  logic         in_req_i,
  output logic         in_ack_o,
  output logic [W-1:0] out_data_o,
  output logic         out_req_o,
  input  logic         out_ack_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] wp_q, rp_q;
  logic [W-1:0] mem_q [DEPTH];
  logic push, pop;
  assign in_ack_o   = (wp_q - rp_q) != PW'(DEPTH);
  assign out_req_o  = wp_q != rp_q;
  assign out_data_o = mem_q[rp_q[AW-1:0]];
  assign push = in_req_i & in_ack_o;
  assign pop  = out_req_o & out_ack_i;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= push ? wp_q + PW'(1) : wp_q;
      rp_q <= pop ? rp_q + PW'(1) : rp_q;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q[AW-1:0]] <= in_data_i;
endmodule

// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: store-and-forward frame buffer; frames become visible only once committed,
// bad or oversize frames are rolled back instead of back-pressuring upstream.
module rx_frame_buffer
  import rx_frame_buffer_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int MAX_WORDS  = 380,
  parameter int DESC_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_pipe_data,
  input  logic              in_pipe_req,
  output logic              in_pipe_ack,
  output logic [WORD_W-1:0] out_pipe_data,
  output logic              out_pipe_req,
  input  logic              out_pipe_ack,
  output logic [15:0]       desc_data,
  output logic              desc_req,
  input  logic              desc_ack,
  output logic [15:0]       good_cnt,
  output logic [15:0]       bad_cnt,
  output logic [15:0]       drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
  ing_state_e st_q, st_d;
  logic [15:0] len_q, len_d, wcnt_q, wcnt_d, nlen;
  logic [15:0] good_q, good_d, bad_q, bad_d, drop_q, drop_d;
  logic acc, last, full, wr_en, push, desc_ok, fifo_req;
  assign in_pipe_ack   = ~reset;
  assign acc           = in_pipe_req & ~reset;
  assign last          = in_pipe_data[LAST_BIT];
  assign full          = (wr_q - rd_q) == PW'(DEPTH);
  assign nlen          = len_q + keep_bytes(in_pipe_data[KEEP_MSB:0]);
  assign out_pipe_req  = (rd_q != cm_q) & ~reset;
  assign out_pipe_data = mem[rd_q[AW-1:0]];
  assign desc_req      = fifo_req & ~reset;
  assign good_cnt      = good_q;
  assign bad_cnt       = bad_q;
  assign drop_cnt      = drop_q;
  always_comb begin
    st_d   = st_q;
    wr_d   = wr_q;
    cm_d   = cm_q;
    len_d  = len_q;
    wcnt_d = wcnt_q;
    good_d = good_q;
    bad_d  = bad_q;
    drop_d = drop_q;
    wr_en  = 1'b0;
    push   = 1'b0;
    rd_d   = (out_pipe_req & out_pipe_ack) ? rd_q + PW'(1) : rd_q;
    if (acc && st_q == DROP) begin
      st_d = last ? IDLE : DROP;
    end else if (acc) begin
      // never write while full: the slot at wr_ptr still holds unread data
      wr_en = ~full;
      if (full || wcnt_q >= 16'(MAX_WORDS) || (last && in_pipe_data != BAD_MARKER && !desc_ok)) begin
        wr_d   = cm_q;
        len_d  = '0;
        wcnt_d = '0;
        drop_d = sat_inc(drop_q);
        st_d   = last ? IDLE : DROP;
      end else if (in_pipe_data == BAD_MARKER) begin
        wr_d   = cm_q;
        len_d  = '0;
        wcnt_d = '0;
        bad_d  = sat_inc(bad_q);
        st_d   = IDLE;
      end else if (last) begin
        wr_d   = wr_q + PW'(1);
        cm_d   = wr_q + PW'(1);
        len_d  = '0;
        wcnt_d = '0;
        push   = 1'b1;
        good_d = sat_inc(good_q);
        st_d   = IDLE;
      end else begin
        wr_d   = wr_q + PW'(1);
        len_d  = nlen;
        wcnt_d = wcnt_q + 16'd1;
        st_d   = RECV;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      wr_q   <= '0;
      cm_q   <= '0;
      rd_q   <= '0;
      len_q  <= '0;
      wcnt_q <= '0;
      good_q <= '0;
      bad_q  <= '0;
      drop_q <= '0;
    end else begin
      st_q   <= st_d;
      wr_q   <= wr_d;
      cm_q   <= cm_d;
      rd_q   <= rd_d;
      len_q  <= len_d;
      wcnt_q <= wcnt_d;
      good_q <= good_d;
      bad_q  <= bad_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk) if (wr_en) mem[wr_q[AW-1:0]] <= in_pipe_data;
  desc_fifo #(.W(16), .DEPTH(DESC_DEPTH)) u_desc (
    .clk       (clk),
    .reset     (reset),
    .in_data_i (nlen),
    .in_req_i  (push),
    .in_ack_o  (desc_ok),
    .out_data_o(desc_data),
    .out_req_o (fifo_req),
    .out_ack_i (desc_ack & ~reset)
  );
endmodule

// File: tb/tb_rx_frame_buffer.sv
// tb_rx_frame_buffer: directed plus random frames checked every cycle against a queue-based frame model
module tb_rx_frame_buffer;
  localparam int DEPTH = 256, MAXW = 380, DD = 16;
  logic clk = 0, reset = 1;
  logic [36:0] in_data = '0;
  logic in_req = 0, oack = 0, dack = 0;
  logic in_ack, out_req, d_req;
  logic [36:0] out_data;
  logic [15:0] d_data, good_cnt, bad_cnt, drop_cnt;
  int n_asrt = 0, n_fail = 0;
  logic [36:0] qw[$];
  logic [36:0] cur[$];
  logic [15:0] qd[$];
  bit dropping;
  int m_good, m_bad, m_drop;

  rx_frame_buffer #(.DEPTH(DEPTH), .MAX_WORDS(MAXW), .DESC_DEPTH(DD)) dut (
    .clk(clk), .reset(reset),
    .in_pipe_data(in_data), .in_pipe_req(in_req), .in_pipe_ack(in_ack),
    .out_pipe_data(out_data), .out_pipe_req(out_req), .out_pipe_ack(oack),
    .desc_data(d_data), .desc_req(d_req), .desc_ack(dack),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat(input int c);
    return c > 65535 ? 16'hFFFF : 16'(c);
  endfunction

  function automatic logic [36:0] mk(input bit l, input logic [31:0] d, input logic [3:0] k);
    return {l, d, k};
  endfunction

  // one accepted word applied to the frame model; occ/nd are buffer and queue sizes before this cycle
  task automatic model_word(input logic [36:0] w, input int occ, input int nd);
    int len;
    if (dropping) begin
      if (w[36]) dropping = 0;
    end else if (occ == DEPTH || cur.size() >= MAXW) begin
      cur.delete();
      m_drop++;
      dropping = !w[36];
    end else if (w[36] && w[35:4] == 32'd1 && w[3:0] == 4'h0) begin
      cur.delete();
      m_bad++;
    end else if (w[36] && nd == DD) begin
      cur.delete();
      m_drop++;
    end else begin
      cur.push_back(w);
      if (w[36]) begin
        len = 0;
        foreach (cur[i]) begin
          len += $countones(cur[i][3:0]);
          qw.push_back(cur[i]);
        end
        qd.push_back(16'(len));
        m_good++;
        cur.delete();
      end
    end
  endtask

  task automatic step(input bit req, input logic [36:0] w, input bit oa, input bit da);
    int occ, nd;
    bit rd, dp;
    in_req = req; in_data = w; oack = oa; dack = da;
    @(negedge clk);
    chk("in_ack", in_ack, 1);
    chk("out_req", out_req, qw.size() > 0);
    if (qw.size() > 0) chk("out_data", out_data, qw[0]);
    chk("desc_req", d_req, qd.size() > 0);
    if (qd.size() > 0) chk("desc_data", d_data, qd[0]);
    chk("good_cnt", good_cnt, sat(m_good));
    chk("bad_cnt", bad_cnt, sat(m_bad));
    chk("drop_cnt", drop_cnt, sat(m_drop));
    occ = qw.size() + cur.size();
    nd = qd.size();
    rd = oa && qw.size() > 0;
    dp = da && qd.size() > 0;
    if (rd) void'(qw.pop_front());
    if (dp) void'(qd.pop_front());
    if (req) model_word(w, occ, nd);
    @(posedge clk); #1;
    in_req = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_in_ack", in_ack, 0);
      chk("rst_out_req", out_req, 0);
      chk("rst_desc_req", d_req, 0);
      @(posedge clk); #1;
    end
    qw.delete(); qd.delete(); cur.delete();
    dropping = 0; m_good = 0; m_bad = 0; m_drop = 0;
    reset = 0; in_req = 0;
  endtask

  task automatic send_frame(input int n, input bit oa, input bit da);
    for (int i = 0; i < n; i++)
      step(1, mk(i == n - 1, $urandom, 4'($urandom_range(1, 15))), oa, da);
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && (qw.size() > 0 || qd.size() > 0); i++) step(0, '0, 1, 1);
  endtask

  logic [36:0] w3[3];
  logic [3:0] k1;
  int exp_len;

  initial begin
    @(posedge clk); #1;
    do_reset(3);
    step(0, '0, 0, 0);
    chk("reset_good", good_cnt, 0);
    chk("reset_drop", drop_cnt, 0);
    // 3-word frame, keeps F,F,3
    w3[0] = mk(0, 32'hA0A0_0001, 4'hF);
    w3[1] = mk(0, 32'hA0A0_0002, 4'hF);
    w3[2] = mk(1, 32'hA0A0_0003, 4'h3);
    for (int i = 0; i < 3; i++) step(1, w3[i], 0, 0);
    step(0, '0, 0, 0);
    chk("f3_desc_len", d_data, 10);
    chk("f3_good", good_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      chk("f3_word", out_data, w3[i]);
      chk("f3_last", out_data[36], i == 2);
      step(0, '0, 1, 0);
    end
    chk("f3_empty", out_req, 0);
    drain();
    // two words then bad-FCS marker
    send_frame(2, 1, 1);
    chk("bad_no_data", out_req, 1);
    drain();
    step(1, mk(0, 32'h1234, 4'hF), 1, 1);
    step(1, mk(0, 32'h5678, 4'hF), 1, 1);
    step(1, mk(1, 32'd1, 4'h0), 1, 1);
    step(0, '0, 1, 1);
    chk("bad_out_req", out_req, 0);
    chk("bad_desc_req", d_req, 0);
    chk("bad_cnt", bad_cnt, 1);
    step(1, mk(1, 32'hBEEF, 4'h7), 0, 0);
    chk("after_bad_word", out_data, mk(1, 32'hBEEF, 4'h7));
    chk("after_bad_len", d_data, 3);
    drain();
    // 300-word frame with no reader overflows the buffer
    send_frame(300, 0, 0);
    chk("ovf_drop", drop_cnt, 1);
    chk("ovf_no_desc", d_req, 0);
    send_frame(4, 0, 0);
    step(0, '0, 0, 0);
    chk("ovf_next_desc", d_req, 1);
    drain();
    // oversize frame with the reader always ready
    send_frame(381, 1, 1);
    step(0, '0, 1, 1);
    chk("big_drop", drop_cnt, 2);
    chk("big_no_desc", d_req, 0);
    // descriptor queue overflow
    for (int i = 0; i < 17; i++) step(1, mk(1, 32'(i), 4'h1), 1, 0);
    step(0, '0, 1, 0);
    chk("dq_drop", drop_cnt, 3);
    chk("dq_good", good_cnt, 2 + 16 + 2);
    drain();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [36:0] w;
      w = ($urandom_range(0, 19) == 0) ? mk(1, 32'd1, 4'h0)
          : mk($urandom_range(0, 7) == 0, $urandom, 4'($urandom_range(0, 15)));
      step($urandom_range(0, 3) != 0, w, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
    end
    drain();
    // reset in the middle of a 10-word frame
    for (int i = 0; i < 4; i++) step(1, mk(0, $urandom, 4'hF), 0, 0);
    in_req = 1; in_data = mk(0, $urandom, 4'hF);
    do_reset(2);
    step(0, '0, 0, 0);
    chk("mrst_out_req", out_req, 0);
    chk("mrst_desc_req", d_req, 0);
    chk("mrst_good", good_cnt, 0);
    k1 = 4'($urandom_range(0, 15));
    exp_len = $countones(k1);
    step(1, mk(1, $urandom, k1), 0, 0);
    step(0, '0, 0, 0);
    chk("mrst_desc_len", d_data, 64'(exp_len));
    chk("mrst_out_req1", out_req, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
